// File: rtl/emc_trig_pkg.sv
// Shared types for the EMCal SRU test-trigger sequencer.
//   trig_state_e : sequencer FSM states (L0 -> L1 -> L2a -> busy hold-off)
//   trig_mode_e  : trig_mode input encodings
package emc_trig_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        L1_WAIT   = 2'd1,
        L2_WAIT   = 2'd2,
        BUSY_WAIT = 2'd3
    } trig_state_e;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SINGLE   = 2'b10,
        MODE_BURST    = 2'b11
    } trig_mode_e;

endpackage

// File: rtl/emc_busy_agg.sv
// Busy aggregator: masked OR of the DTC busy lines plus the external busy,
// registered once so that busy seen in cycle t gates requests in cycle t+1.
// Ports:
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   busy_i     : per-channel busy
//   mask_i     : 1 = channel participates
//   ext_busy_i : external busy
//   agg_busy_o : registered aggregate busy
module emc_busy_agg #(
    parameter int unsigned NCH = 40
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [NCH-1:0] busy_i,
    input  logic [NCH-1:0] mask_i,
    input  logic           ext_busy_i,
    output logic           agg_busy_o
);

    logic agg_q;
    logic agg_d;

    always_comb begin
        agg_d = (|(busy_i & mask_i)) | ext_busy_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            agg_q <= 1'b0;
        end else begin
            agg_q <= agg_d;
        end
    end

    assign agg_busy_o = agg_q;

endmodule

// File: rtl/emc_test_trig_gen.sv
// Test-trigger sequencer for the EMCal SRU. Generates L0/L1/L2a pulse
// trains in periodic, single-shot or burst mode, gated by aggregated busy,
// and counts accepted events and rejected requests.
// Ports:
//   clk40, reset_n                : clock, synchronous active-low reset
//   trig_en, trig_mode, sw_trig   : enable, mode (00 off/01 per/10 single/11 burst), sw trigger
//   period, l1_delay, l2_delay    : request period, L0->L1 and L1->L2a spacing minus 1
//   burst_len                     : events per burst
//   rdo_mask, dtc_busy, ext_busy  : busy sources
//   evcnt_clr                     : event counter clear
//   l0, l1, l2a                   : trigger pulses
//   busy_out, burst_done          : status
//   ev_cnt, rej_cnt               : accepted events, rejected requests (saturating)
module emc_test_trig_gen
    import emc_trig_pkg::*;
#(
    parameter int unsigned NCH = 40,
    parameter int unsigned CW  = 16,
    parameter int unsigned EVW = 24
) (
    input  logic           clk40,
    input  logic           reset_n,
    input  logic           trig_en,
    input  logic [1:0]     trig_mode,
    input  logic           sw_trig,
    input  logic [CW-1:0]  period,
    input  logic [CW-1:0]  l1_delay,
    input  logic [CW-1:0]  l2_delay,
    input  logic [7:0]     burst_len,
    input  logic [NCH-1:0] rdo_mask,
    input  logic [NCH-1:0] dtc_busy,
    input  logic           ext_busy,
    input  logic           evcnt_clr,
    output logic           l0,
    output logic           l1,
    output logic           l2a,
    output logic           busy_out,
    output logic           burst_done,
    output logic [EVW-1:0] ev_cnt,
    output logic [CW-1:0]  rej_cnt
);

    logic agg_busy_r;

    emc_busy_agg #(.NCH(NCH)) u_busy_agg (
        .clk_i      (clk40),
        .rst_ni     (reset_n),
        .busy_i     (dtc_busy),
        .mask_i     (rdo_mask),
        .ext_busy_i (ext_busy),
        .agg_busy_o (agg_busy_r)
    );

    trig_state_e    state_q, state_d;
    logic [CW-1:0]  dly_q, dly_d;
    logic [CW-1:0]  pcnt_q, pcnt_d;
    logic [CW-1:0]  term_q, term_d;
    logic [CW-1:0]  rej_q, rej_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [EVW-1:0] ev_q, ev_d;
    logic           l0_q, l0_d, l1_q, l1_d, l2a_q, l2a_d, done_q, done_d;

    logic           per_act, burst_act, term_hit, req, burst_full, accept;
    logic [CW-1:0]  period_m1;

    always_comb begin
        per_act    = trig_en && (trig_mode == MODE_PERIODIC || trig_mode == MODE_BURST);
        burst_act  = trig_en && (trig_mode == MODE_BURST);
        period_m1  = (period == '0) ? '0 : period - CW'(1);
        term_hit   = per_act && (pcnt_q == term_q);
        req        = term_hit || (trig_en && trig_mode == MODE_SINGLE && sw_trig);
        // a finished burst swallows requests silently rather than rejecting them
        burst_full = burst_act && (bcnt_q >= burst_len);
        accept     = req && !burst_full && (state_q == IDLE) && !agg_busy_r;

        // terminal value is reloaded whenever the counter sits at 0, so a
        // period change only lands at the next wrap
        pcnt_d = '0;
        term_d = period_m1;
        if (per_act && !term_hit) begin
            pcnt_d = pcnt_q + CW'(1);
            term_d = term_q;
        end

        state_d = state_q;
        dly_d   = dly_q;
        l0_d    = 1'b0;
        l1_d    = 1'b0;
        l2a_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    l0_d    = 1'b1;
                    dly_d   = l1_delay;
                    state_d = L1_WAIT;
                end
            end
            L1_WAIT: begin
                if (dly_q == '0) begin
                    l1_d    = 1'b1;
                    dly_d   = l2_delay;
                    state_d = L2_WAIT;
                end else begin
                    dly_d = dly_q - CW'(1);
                end
            end
            L2_WAIT: begin
                if (dly_q == '0) begin
                    l2a_d   = 1'b1;
                    state_d = BUSY_WAIT;
                end else begin
                    dly_d = dly_q - CW'(1);
                end
            end
            BUSY_WAIT: begin
                if (!agg_busy_r) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ev_d = ev_q;
        if (evcnt_clr) begin
            ev_d = '0;
        end else if (l2a_d) begin
            ev_d = ev_q + EVW'(1);
        end

        rej_d = rej_q;
        if (req && !burst_full && !accept && rej_q != '1) begin
            rej_d = rej_q + CW'(1);
        end

        // completed events are counted at L2a; since acceptance needs IDLE,
        // every earlier event has completed before the next can be accepted
        bcnt_d = bcnt_q;
        if (!burst_act) begin
            bcnt_d = '0;
        end else if (l2a_d && bcnt_q != '1) begin
            bcnt_d = bcnt_q + 8'd1;
        end
        done_d = burst_act && (bcnt_d >= burst_len);
    end

    always_ff @(posedge clk40) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dly_q   <= '0;
            pcnt_q  <= '0;
            term_q  <= '0;
            rej_q   <= '0;
            bcnt_q  <= '0;
            ev_q    <= '0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
            l2a_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            pcnt_q  <= pcnt_d;
            term_q  <= term_d;
            rej_q   <= rej_d;
            bcnt_q  <= bcnt_d;
            ev_q    <= ev_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2a_q   <= l2a_d;
            done_q  <= done_d;
        end
    end

    assign l0         = l0_q;
    assign l1         = l1_q;
    assign l2a        = l2a_q;
    assign burst_done = done_q;
    assign ev_cnt     = ev_q;
    assign rej_cnt    = rej_q;
    // built only from flops, so it moves on the same edge as l0
    assign busy_out   = (state_q != IDLE) | agg_busy_r;

endmodule

// File: tb/tb_emc_test_trig_gen.sv
// Self-checking bench for emc_test_trig_gen: an event-time model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_emc_test_trig_gen;

    localparam int NCH = 40;
    localparam int CW  = 16;
    localparam int EVW = 8;

    logic           clk40 = 1'b0;
    logic           reset_n, trig_en, sw_trig, ext_busy, evcnt_clr;
    logic [1:0]     trig_mode;
    logic [CW-1:0]  period, l1_delay, l2_delay;
    logic [7:0]     burst_len;
    logic [NCH-1:0] rdo_mask, dtc_busy;
    logic           l0, l1, l2a, busy_out, burst_done;
    logic [EVW-1:0] ev_cnt;
    logic [CW-1:0]  rej_cnt;

    emc_test_trig_gen #(.NCH(NCH), .CW(CW), .EVW(EVW)) dut (
        .clk40(clk40), .reset_n(reset_n), .trig_en(trig_en), .trig_mode(trig_mode),
        .sw_trig(sw_trig), .period(period), .l1_delay(l1_delay), .l2_delay(l2_delay),
        .burst_len(burst_len), .rdo_mask(rdo_mask), .dtc_busy(dtc_busy),
        .ext_busy(ext_busy), .evcnt_clr(evcnt_clr), .l0(l0), .l1(l1), .l2a(l2a),
        .busy_out(busy_out), .burst_done(burst_done), .ev_cnt(ev_cnt), .rej_cnt(rej_cnt)
    );

    always #5 clk40 = ~clk40;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- model state (absolute cycle times) ----------------
    longint cyc = 0;
    bit     m_idle = 1, m_seq = 0, m_agg = 0, m_done = 0;
    longint m_t0 = 0, m_t1 = 0, m_t2 = 0, m_fire = 0;
    int     m_nb = 0, m_ev = 0, m_rej = 0;
    // observed-pulse monitor
    int     n_l0 = 0, n_l1 = 0, n_l2 = 0;
    longint o_t0 = 0, o_t0p = 0, o_t1 = 0, o_t2 = 0;

    initial begin : compare
        longint c, e, pmax;
        bit pact, bact, req, full, acc, l2now;
        forever begin
            @(posedge clk40);
            #1;
            cyc++;
            e = cyc;
            c = cyc - 1;
            if (!reset_n) begin
                m_idle = 1; m_seq = 0; m_agg = 0; m_fire = e;
                m_nb = 0; m_ev = 0; m_rej = 0; m_done = 0;
            end else begin
                pact = trig_en && (trig_mode == 2'b01 || trig_mode == 2'b11);
                bact = trig_en && (trig_mode == 2'b11);
                pmax = (period == 0) ? 1 : longint'(period);
                req  = 0;
                if (pact) begin
                    if (c == m_fire) begin
                        req = 1;
                        m_fire = c + pmax;
                    end
                end else begin
                    m_fire = c + pmax;
                end
                if (trig_en && trig_mode == 2'b10 && sw_trig) req = 1;
                full = bact && (m_nb >= int'(burst_len));
                acc  = req && !full && m_idle && !m_agg;
                if (req && !full && !acc && m_rej < 65535) m_rej++;
                if (!m_idle && c >= m_t2 && !m_agg) m_idle = 1;
                if (acc) begin
                    m_idle = 0;
                    m_seq  = 1;
                    m_t0   = e;
                    m_t1   = e + longint'(l1_delay) + 1;
                    m_t2   = m_t1 + longint'(l2_delay) + 1;
                end
                l2now = m_seq && (e == m_t2);
                if (evcnt_clr) m_ev = 0;
                else if (l2now) m_ev = (m_ev + 1) % (1 << EVW);
                if (!bact) m_nb = 0;
                else if (l2now) m_nb++;
                m_done = bact && (m_nb >= int'(burst_len));
                m_agg  = (|(dtc_busy & rdo_mask)) | ext_busy;
            end
            chk("l0",         l0,         64'(m_seq && e == m_t0));
            chk("l1",         l1,         64'(m_seq && e == m_t1));
            chk("l2a",        l2a,        64'(m_seq && e == m_t2));
            chk("busy_out",   busy_out,   64'(!m_idle || m_agg));
            chk("burst_done", burst_done, 64'(m_done));
            chk("ev_cnt",     ev_cnt,     64'(m_ev));
            chk("rej_cnt",    rej_cnt,    64'(m_rej));
            if (l0 === 1'b1)  begin n_l0++; o_t0p = o_t0; o_t0 = cyc; end
            if (l1 === 1'b1)  begin n_l1++; o_t1 = cyc; end
            if (l2a === 1'b1) begin n_l2++; o_t2 = cyc; end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk40);
    endtask

    function automatic logic pulse_sel(input int w);
        case (w)
            0:       return l0;
            1:       return l1;
            default: return l2a;
        endcase
    endfunction

    task automatic wait_pulse(input int w, input string nm);
        int n = 0;
        while (pulse_sel(w) !== 1'b1 && n < 50) begin
            @(negedge clk40);
            n++;
        end
        chk(nm, pulse_sel(w), 1);
    endtask

    task automatic wait_ev(input int val, input string nm);
        int n = 0;
        while (ev_cnt !== EVW'(val) && n < 3000) begin
            @(negedge clk40);
            n++;
        end
        chk(nm, ev_cnt, val);
    endtask

    initial begin : stim
        int r0, n0, n2;
        reset_n = 0; trig_en = 0; trig_mode = 2'b00; sw_trig = 0;
        period = 16'd100; l1_delay = 16'd3; l2_delay = 16'd10; burst_len = 8'd3;
        rdo_mask = '1; dtc_busy = '0; ext_busy = 0; evcnt_clr = 0;

        // reset state
        tick(3);
        chk("rst_l0", l0, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ev", ev_cnt, 0);
        chk("rst_rej", rej_cnt, 0);
        chk("rst_done", burst_done, 0);
        reset_n = 1;
        tick(1);

        // periodic, period 100, l1 +4, l2a +11
        trig_mode = 2'b01; trig_en = 1;
        tick(520);
        chk("per_n_l0", n_l0, 5);
        chk("per_n_l2", n_l2, 5);
        chk("per_ev", ev_cnt, 5);
        chk("per_rej", rej_cnt, 0);
        chk("per_l0_l1", o_t1 - o_t0, 4);
        chk("per_l1_l2", o_t2 - o_t1, 11);
        chk("per_period", o_t0 - o_t0p, 100);

        // busy on a masked-out channel is ignored
        rdo_mask[39] = 0; dtc_busy[39] = 1;
        n0 = n_l0;
        tick(200);
        chk("mask_off_l0", n_l0 - n0, 2);
        // unmask: every period now rejects
        rdo_mask[39] = 1;
        tick(1);
        r0 = rej_cnt; n0 = n_l0;
        tick(300);
        chk("mask_on_rej", rej_cnt - r0, 3);
        chk("mask_on_l0", n_l0 - n0, 0);
        dtc_busy[39] = 0;
        tick(150);

        // burst of 3, period 50
        trig_en = 0; period = 16'd50;
        tick(20);
        trig_mode = 2'b11; trig_en = 1;
        n2 = n_l2; r0 = rej_cnt;
        tick(300);
        chk("burst1_l2", n_l2 - n2, 3);
        chk("burst1_done", burst_done, 1);
        chk("burst1_rej", rej_cnt - r0, 0);
        trig_en = 0;
        tick(1);
        chk("burst_clr", burst_done, 0);
        trig_en = 1;
        n2 = n_l2;
        tick(300);
        chk("burst2_l2", n_l2 - n2, 3);
        chk("burst2_done", burst_done, 1);
        // burst_len 0
        trig_en = 0; burst_len = 8'd0;
        tick(1);
        trig_en = 1;
        n0 = n_l0; r0 = rej_cnt;
        tick(1);
        chk("burst0_done", burst_done, 1);
        tick(199);
        chk("burst0_l0", n_l0 - n0, 0);
        chk("burst0_rej", rej_cnt - r0, 0);

        // single-shot, zero delays, after a fresh reset
        trig_en = 0; trig_mode = 2'b10; burst_len = 8'd3;
        l1_delay = 16'd0; l2_delay = 16'd0; reset_n = 0;
        tick(2);
        reset_n = 1;
        tick(1);
        trig_en = 1;
        tick(1);
        sw_trig = 1;
        tick(1);
        chk("ss_l0", l0, 1);
        chk("ss_l0_only", {l1, l2a}, 0);
        chk("ss_busy", busy_out, 1);
        sw_trig = 0;
        tick(1);
        chk("ss_l1", l1, 1);
        chk("ss_l1_only", {l0, l2a}, 0);
        sw_trig = 1;
        tick(1);
        chk("ss_l2a", l2a, 1);
        chk("ss_ev", ev_cnt, 1);
        sw_trig = 0;
        tick(1);
        chk("ss_rej", rej_cnt, 1);
        chk("ss_idle", busy_out, 0);

        // reset while in L2_WAIT
        l2_delay = 16'd10;
        tick(2);
        sw_trig = 1;
        tick(1);
        sw_trig = 0;
        tick(4);
        reset_n = 0;
        tick(1);
        chk("rl2_pulses", {l0, l1, l2a}, 0);
        chk("rl2_busy", busy_out, 0);
        chk("rl2_done", burst_done, 0);
        chk("rl2_ev", ev_cnt, 0);
        chk("rl2_rej", rej_cnt, 0);
        reset_n = 1;
        n2 = n_l2;
        tick(20);
        chk("rl2_no_l2a", n_l2 - n2, 0);

        // event counter wrap, then clear coincident with l2a
        l2_delay = 16'd0; period = 16'd4; trig_mode = 2'b01;
        wait_ev(255, "wrap_reach_max");
        tick(1);
        wait_pulse(2, "wrap_l2a");
        chk("wrap_to_0", ev_cnt, 0);
        wait_ev(255, "clr_reach_max");
        tick(1);
        wait_pulse(1, "clr_l1");
        evcnt_clr = 1;
        tick(1);
        chk("clr_l2a", l2a, 1);
        chk("clr_ev", ev_cnt, 0);
        evcnt_clr = 0;
        tick(1);
        chk("clr_ev_hold", ev_cnt, 0);

        // disable mid-sequence: sequence still completes
        tick(1);
        wait_pulse(0, "midoff_l0");
        trig_en = 0;
        n2 = n_l2;
        tick(10);
        chk("midoff_l2a", n_l2 - n2, 1);
        chk("midoff_idle", busy_out, 0);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/emc_test_trig_gen.md
Name: emc_test_trig_gen

Overview:
- Parametrised, synthesisable test-trigger sequencer for the EMCal SRU. It generates L0/L1/L2-accept pulse trains in periodic, single-shot or burst mode.
- Trigger requests are gated by a masked aggregate of N DTC busy lines plus an external busy. It counts accepted and rejected events.
- It replaces fixed simulation trigger settings with run-time registers. It sits between the SRU command/config registers and the trigger distribution to the DTC links.

Parameters:
- NCH, 40, number of DTC channels (busy and mask width)
- CW, 16, width of the period, l1_delay, l2_delay and rej_cnt fields
- EVW, 24, width of the event counter

Ports:
- clk40  in  1  TTC-domain clock
- reset_n  in  1  synchronous, active-low reset
- trig_en  in  1  global enable
- trig_mode  in  2  00 off, 01 periodic, 10 single-shot, 11 burst
- sw_trig  in  1  one-cycle software trigger (single-shot mode)
- period  in  CW  request period in clk40 cycles (0 treated as 1)
- l1_delay  in  CW  L0-to-L1 spacing minus 1
- l2_delay  in  CW  L1-to-L2a spacing minus 1
- burst_len  in  8  events per burst
- rdo_mask  in  NCH  1 = channel participates in busy
- dtc_busy  in  NCH  per-channel busy
- ext_busy  in  1  external busy input
- evcnt_clr  in  1  event counter clear
- l0  out  1  L0 pulse
- l1  out  1  L1 pulse
- l2a  out  1  L2-accept pulse
- busy_out  out  1  sequencer or aggregate busy
- burst_done  out  1  burst complete
- ev_cnt  out  EVW  accepted events
- rej_cnt  out  CW  rejected requests

Behaviour:
- Reset (reset_n low at a clk40 edge): all outputs 0; FSM to IDLE; all counters 0. Reset mid-sequence aborts the sequence with no trailing pulses.
- Busy aggregation: agg_busy_r is registered as |(dtc_busy & rdo_mask) | ext_busy. It has 1-cycle latency, so busy sampled at cycle t gates requests at t+1.
- Request sources:
  - Periodic and burst: the period counter counts 0..max(period,1)-1 while trig_en=1 and mode is 01 or 11. A request fires at the terminal count, then the counter wraps to 0.
  - Single-shot: a request fires on any cycle with sw_trig=1, trig_en=1 and mode 10.
  - trig_en=0 or mode 00: the period counter is held at 0 and no requests are made.
- Acceptance: a request is accepted only in IDLE with agg_busy_r=0. Otherwise rej_cnt increments, saturating at all-ones.
- FSM: IDLE -> L1_WAIT -> L2_WAIT -> BUSY_WAIT -> IDLE.
  - Accept at cycle t: l0=1 at t+1; the delay counter loads l1_delay; go to L1_WAIT.
  - L1_WAIT: decrement; at 0, assert l1 for one cycle, which is exactly l1_delay+1 cycles after l0. Load l2_delay; go to L2_WAIT.
  - L2_WAIT: at 0, assert l2a for one cycle, l2_delay+1 cycles after l1. ev_cnt increments (wraps modulo 2^EVW). Go to BUSY_WAIT.
  - BUSY_WAIT: stay at least 1 cycle; return to IDLE on the first cycle with agg_busy_r=0.
- busy_out = (state != IDLE) | agg_busy_r. It is registered and changes together with l0.
- Each of l0, l1 and l2a is high for exactly one cycle per event. They are never simultaneous, including when l1_delay=l2_delay=0 (l0, l1, l2a then occur on consecutive cycles).
- Burst mode:
  - Accepted events are counted; after burst_len events, burst_done=1 and further requests are ignored (not counted as rejects).
  - Clear burst_done and the burst count with trig_en=0 or a mode change.
  - burst_len=0 sets burst_done immediately and produces no triggers.
- trig_en deasserted or trig_mode changed mid-sequence: the current sequence runs to l2a and BUSY_WAIT with no truncation. New requests follow the new settings from the next cycle.
- Delay and period inputs are sampled only at load (accept or terminal count); changes mid-count take effect on the next load.
- evcnt_clr: ev_cnt=0 next cycle. Clear has priority over a coincident increment, and that event is not counted.

Decomposition:
- Package emc_trig_pkg: FSM state enum (IDLE, L1_WAIT, L2_WAIT, BUSY_WAIT) and trig_mode constants (MODE_OFF, MODE_PERIODIC, MODE_SINGLE, MODE_BURST).
- Sub-module emc_busy_agg (parameter NCH): masked OR plus output register, producing agg_busy_r.

Test Plan:
- Periodic, period=100, l1_delay=3, l2_delay=10, no busy: l0 every 100 cycles; l1 4 cycles after l0; l2a 11 cycles after l1; ev_cnt=5 after 5 periods; rej_cnt=0.
- Masked busy: dtc_busy[39] held 1 with rdo_mask[39]=0 gives no effect; after setting rdo_mask[39]=1, l0 stops and rej_cnt increments by 1 per period until busy drops.
- Burst, burst_len=3, period=50: exactly 3 l2a pulses, then burst_done=1; toggling trig_en low then high starts a new burst of 3; burst_len=0 gives burst_done=1 and no l0.
- Single-shot: sw_trig at cycle 10 with l1_delay=l2_delay=0 gives l0 at 11, l1 at 12, l2a at 13; a second sw_trig at cycle 12 gives rej_cnt=1.
- Reset in L2_WAIT: l2a never fires; all outputs 0 on the cycle after the reset edge; ev_cnt=0.
- evcnt_clr coincident with l2a at ev_cnt=0xFFFFFF: ev_cnt=0; a separate run with no clear wraps 0xFFFFFF to 0.
